// File: rtl/vga_pkg.sv
// Shared VGA definitions: character ROM widths and arbiter helpers.
// Imported by the character ROM arbiter.
package vga_pkg;

  localparam int CHAR_XY_W   = 8;
  localparam int CHAR_CODE_W = 7;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_0    = 2'd1,
    GNT_1    = 2'd2
  } gnt_e;

  // Counter must hold 0..limit, and never shrink below one bit.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/char_rom_arbiter.sv
// Two-port front end for one shared combinational character ROM.
// Port 0 has priority; port 1 is force-granted after a bounded wait.
module char_rom_arbiter
  import vga_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XY_W         = CHAR_XY_W,
  parameter int CODE_W       = CHAR_CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [XY_W-1:0]   req0_xy,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [CODE_W-1:0] rsp0_code,
  input  logic              req1_valid,
  input  logic [XY_W-1:0]   req1_xy,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [CODE_W-1:0] rsp1_code,
  output logic [XY_W-1:0]   rom_xy,
  input  logic [CODE_W-1:0] rom_code
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  gnt_e              w_gnt;
  logic              w_sat;
  logic              w_hs0;
  logic              w_hs1;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_rsp0_valid;
  logic [CODE_W-1:0] r_rsp0_code;
  logic              r_rsp1_valid;
  logic [CODE_W-1:0] r_rsp1_code;

  assign w_sat = (r_starve_cnt == LIM);

  // Grant: port 1 wins when alone or when its wait has saturated.
  always_comb begin
    w_gnt = GNT_NONE;
    if (req1_valid && (!req0_valid || w_sat)) begin
      w_gnt = GNT_1;
    end else if (req0_valid) begin
      w_gnt = GNT_0;
    end
  end

  assign req0_ready = (w_gnt == GNT_0);
  assign req1_ready = (w_gnt == GNT_1);
  assign w_hs0      = req0_valid && req0_ready;
  assign w_hs1      = req1_valid && req1_ready;

  // Steer the shared ROM to the winner; park at zero when idle.
  always_comb begin
    rom_xy = '0;
    unique case (w_gnt)
      GNT_0:   rom_xy = req0_xy;
      GNT_1:   rom_xy = req1_xy;
      default: rom_xy = '0;
    endcase
  end

  // Count contended losses of port 1; any gap in its request drops credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!req1_valid || (w_gnt == GNT_1)) begin
      r_starve_cnt <= '0;
    end else if ((w_gnt == GNT_0) && !w_sat) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Port 0 response: one-cycle pulse, code held between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_code  <= '0;
    end else begin
      r_rsp0_valid <= w_hs0;
      if (w_hs0) begin
        r_rsp0_code <= rom_code;
      end
    end
  end

  // Port 1 response: one-cycle pulse, code held between lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_code  <= '0;
    end else begin
      r_rsp1_valid <= w_hs1;
      if (w_hs1) begin
        r_rsp1_code <= rom_code;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_code  = r_rsp0_code;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_code  = r_rsp1_code;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter with a start-screen ROM model.
// Runs a default build and a STARVE_LIMIT = 0 build side by side.
module tb_char_rom_arbiter;

  localparam logic [6:0] CODE_Z = 7'h5a;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_xy;
  logic       req1_valid;
  logic [7:0] req1_xy;

  logic       a_r0, a_r1, a_v0, a_v1;
  logic [6:0] a_c0, a_c1, a_rc;
  logic [7:0] a_rx;
  logic       b_r0, b_r1, b_v0, b_v1;
  logic [6:0] b_c0, b_c1, b_rc;
  logic [7:0] b_rx;

  int n_chk;
  int n_fail;

  logic [3:0] tbl [20];

  function automatic logic [6:0] rom_f(input logic [7:0] xy);
    if (xy[7:4] == 4'hf) return 7'h0e;
    if (xy == 8'h05) return CODE_Z;
    return xy[6:0] ^ 7'h2a;
  endfunction

  assign a_rc = rom_f(a_rx);
  assign b_rc = rom_f(b_rx);

  char_rom_arbiter #(.STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_xy(req0_xy), .req0_ready(a_r0),
    .rsp0_valid(a_v0), .rsp0_code(a_c0),
    .req1_valid(req1_valid), .req1_xy(req1_xy), .req1_ready(a_r1),
    .rsp1_valid(a_v1), .rsp1_code(a_c1),
    .rom_xy(a_rx), .rom_code(a_rc)
  );

  char_rom_arbiter #(.STARVE_LIMIT(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_xy(req0_xy), .req0_ready(b_r0),
    .rsp0_valid(b_v0), .rsp0_code(b_c0),
    .req1_valid(req1_valid), .req1_xy(req1_xy), .req1_ready(b_r1),
    .rsp1_valid(b_v1), .rsp1_code(b_c1),
    .rom_xy(b_rx), .rom_code(b_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic v0, v1, e0, e1;
    n_chk  = 0;
    n_fail = 0;
    // {v0, v1, exp_ready0, exp_ready1}
    tbl = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101,
            4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101,
            4'b1110, 4'b1110, 4'b1010,
            4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101,
            4'b0101, 4'b0000};

    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_xy    = 8'hf0;
    req1_valid = 1'b1;
    req1_xy    = 8'h05;
    repeat (3) tick();
    chk("rst_v0", a_v0, 0);
    chk("rst_v1", a_v1, 0);
    chk("rst_c0", a_c0, 0);
    chk("rst_c1", a_c1, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_r0", a_r0, 1);
    chk("rel_r1", a_r1, 0);
    chk("rel_b_r0", b_r0, 0);
    chk("rel_b_r1", b_r1, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Single requester 0 lookup
    req0_valid = 1'b1;
    req0_xy    = 8'hf0;
    #1;
    chk("single_r0", a_r0, 1);
    chk("single_rom", a_rx, 8'hf0);
    tick();
    req0_valid = 1'b0;
    chk("single_v0", a_v0, 1);
    chk("single_c0", a_c0, 7'h0e);
    chk("single_v1", a_v1, 0);
    #1;
    chk("idle_rom", a_rx, 8'h00);
    tick();
    chk("single_v0_drop", a_v0, 0);
    chk("single_c0_hold", a_c0, 7'h0e);

    // Contention, starvation and credit loss
    req0_xy = 8'hf0;
    req1_xy = 8'h05;
    for (int i = 0; i < 20; i++) begin
      {v0, v1, e0, e1} = tbl[i];
      req0_valid = v0;
      req1_valid = v1;
      #1;
      chk($sformatf("tbl%0d_r0", i), a_r0, e0);
      chk($sformatf("tbl%0d_r1", i), a_r1, e1);
      chk($sformatf("tbl%0d_rom", i), a_rx,
          e1 ? 8'h05 : (e0 ? 8'hf0 : 8'h00));
      chk($sformatf("tbl%0d_b_r0", i), b_r0, v0 && !v1);
      chk($sformatf("tbl%0d_b_r1", i), b_r1, v1);
      tick();
      chk($sformatf("tbl%0d_v0", i), a_v0, e0);
      chk($sformatf("tbl%0d_v1", i), a_v1, e1);
      if (e1) chk($sformatf("tbl%0d_c1", i), a_c1, CODE_Z);
    end

    // Back-to-back stream on port 0
    req1_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1'b1;
      req0_xy    = 8'(8'hf0 + i);
      #1;
      chk($sformatf("b2b%0d_r0", i), a_r0, 1);
      tick();
      chk($sformatf("b2b%0d_v0", i), a_v0, 1);
      chk($sformatf("b2b%0d_c0", i), a_c0, 7'h0e);
    end
    req0_valid = 1'b0;
    tick();
    chk("b2b_end_v0", a_v0, 0);

    // Reset with saturated counter and a live response
    req0_valid = 1'b1;
    req0_xy    = 8'hf0;
    req1_valid = 1'b1;
    req1_xy    = 8'h05;
    repeat (4) tick();
    chk("pre_rst_v0", a_v0, 1);
    chk("pre_rst_r1", a_r1, 1);
    rst_n = 1'b0;
    #1;
    chk("async_v0", a_v0, 0);
    chk("async_c0", a_c0, 0);
    tick();
    chk("held_v0", a_v0, 0);
    chk("held_v1", a_v1, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_r0", a_r0, 1);
    chk("post_rst_r1", a_r1, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Reset during a port 1 handshake: response never delivered
    req1_valid = 1'b1;
    req1_xy    = 8'h05;
    #1;
    chk("hs1_r1", a_r1, 1);
    rst_n = 1'b0;
    tick();
    chk("lost_v1_a", a_v1, 0);
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("lost_v1_b", a_v1, 0);
    chk("lost_c1", a_c1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
